dr_phase_tracker_elastic: RTL and testbench

Parametrised successor to the fixed-ratio data recovery path (dr_toplevel). It takes OVERSAMPLE parallel phase samples of the USB2 line per clock_480 cycle and tracks the eye centre with a vote-filtered phase pointer. It emits 0, 1 or 2 recovered bits per cycle to absorb ±ppm Tx/Rx drift. An internal elastic FIFO then re-times those bits to a steady 1 bit/cycle stream with valid, fill level and sticky overflow/underflow flags.

---
 rtl/dr_phase_tracker_elastic.sv | 183 ++++++++++++++++++
 tb/tb_dr_phase_tracker_elastic.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dr_phase_tracker_elastic.sv
// Purpose: oversampled USB2 bit recovery; vote-filtered eye-centre tracking feeding an elastic re-timing FIFO.
// Latency: output starts once FIFO_START bits are buffered, then 1 cycle from FIFO pop to data_out/data_valid.
// Backpressure: none upstream; a full FIFO drops the later bit (sticky overflow), an empty pop drops valid and refills.
module dr_phase_tracker_elastic #(
    parameter int OVERSAMPLE  = 10,
    parameter int LOCK_THRESH = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int FIFO_START  = 8
) (
    input  logic                          clock_480,
    input  logic                          reset,
    input  logic [OVERSAMPLE-1:0]         samples,
    output logic                          data_out,
    output logic                          data_valid,
    output logic [$clog2(OVERSAMPLE)-1:0] phase,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          underflow
);
    localparam int PW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = AW + 1;
    localparam int VW = $clog2(LOCK_THRESH + 1) + 1;

    localparam logic [PW:0]          OS_W     = (PW+1)'(OVERSAMPLE);
    localparam logic [PW:0]          HALF_W   = (PW+1)'(OVERSAMPLE / 2);
    localparam logic [PW-1:0]        SIDX_RST = PW'(OVERSAMPLE / 2);
    localparam logic [PW-1:0]        SIDX_MAX = PW'(OVERSAMPLE - 1);
    localparam logic signed [VW-1:0] VOTE_HI  = VW'(LOCK_THRESH - 1);
    localparam logic signed [VW-1:0] VOTE_LO  = VW'(1 - LOCK_THRESH);
    localparam logic [FW-1:0]        DEPTH_W  = FW'(FIFO_DEPTH);
    localparam logic [FW-1:0]        START_W  = FW'(FIFO_START);

    typedef enum logic {FILL = 1'b0, STREAM = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         sidx, sidx_d;
    logic signed [VW-1:0]  vote, vote_d;
    logic                  prev_last;
    logic                  skip_next, skip_d;

    logic [OVERSAMPLE-1:0] edges;
    logic                  one_edge;
    logic [PW-1:0]         edge_pos;
    logic [PW:0]           eph_sum, ephase, diff_raw, diff;
    logic                  vote_up, vote_dn, step_up, step_dn;

    logic [1:0]            push_cnt;
    logic                  push_b0, push_b1;

    logic                  mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [FW-1:0]         fill, fill_d, room;
    logic                  pop, drop;
    logic [1:0]            accept;

    assign phase      = sidx;
    assign fill_level = fill;

    // Transition map across the UI, seamed to the last sample of the previous cycle; locate a lone edge.
    always_comb begin
        edges    = samples ^ {samples[OVERSAMPLE-2:0], prev_last};
        one_edge = (edges != '0) && ((edges & (edges - OVERSAMPLE'(1))) == '0);
        edge_pos = '0;
        for (int k = 0; k < OVERSAMPLE; k++) begin
            if (edges[k]) edge_pos = PW'(k);
        end
    end

    // Signed phase error of the lone edge versus where the edge should sit for the current sample index.
    always_comb begin
        eph_sum  = {1'b0, sidx} + HALF_W;
        ephase   = (eph_sum >= OS_W) ? eph_sum - OS_W : eph_sum;
        diff_raw = {1'b0, edge_pos} + OS_W - ephase;
        diff     = (diff_raw >= OS_W) ? diff_raw - OS_W : diff_raw;
        // diff in [0, OS/2) is a late edge (d >= 0), [OS/2, OS) wraps to a negative (early) error.
        vote_up  = one_edge && (diff != '0) && (diff < HALF_W);
        vote_dn  = one_edge && (diff >= HALF_W);
    end

    // Vote filter: the pointer moves one step only after LOCK_THRESH net votes in one direction.
    always_comb begin
        vote_d  = vote;
        sidx_d  = sidx;
        step_up = 1'b0;
        step_dn = 1'b0;
        if (vote_up) begin
            if (vote == VOTE_HI) begin
                step_up = 1'b1;
                vote_d  = '0;
                sidx_d  = (sidx == SIDX_MAX) ? '0 : sidx + PW'(1);
            end else begin
                vote_d  = vote + VW'(1);
            end
        end else if (vote_dn) begin
            if (vote == VOTE_LO) begin
                step_dn = 1'b1;
                vote_d  = '0;
                sidx_d  = (sidx == '0) ? SIDX_MAX : sidx - PW'(1);
            end else begin
                vote_d  = vote - VW'(1);
            end
        end
    end

    // Bit emission: a backward wrap recovers an extra bit this cycle, a forward wrap owes one skipped cycle.
    always_comb begin
        push_cnt = 2'd1;
        push_b0  = samples[sidx];
        push_b1  = samples[OVERSAMPLE-1];
        skip_d   = step_up && (sidx == SIDX_MAX);
        if (skip_next) begin
            push_cnt = 2'd0;
        end else if (step_dn && (sidx == '0)) begin
            push_cnt = 2'd2;
            push_b0  = samples[0];
        end
    end

    // FIFO accounting: pop is decided on pre-push occupancy, so a same-cycle pop frees one slot for pushes.
    always_comb begin
        pop    = (state_q == STREAM) && (fill != '0);
        room   = DEPTH_W - fill + FW'(pop);
        drop   = FW'(push_cnt) > room;
        accept = drop ? room[1:0] : push_cnt;
        fill_d = fill - FW'(pop) + FW'(accept);
    end

    // Output FSM next state: start streaming once the buffer reaches the start mark, refill after an empty pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:   if (fill_d >= START_W) state_d = STREAM;
            STREAM: if (fill == '0)        state_d = FILL;
        endcase
    end

    // Tracker state, FIFO pointers, FSM register and registered output stage.
    always_ff @(posedge clock_480 or negedge reset) begin
        if (!reset) begin
            sidx       <= SIDX_RST;
            vote       <= '0;
            prev_last  <= 1'b0;
            skip_next  <= 1'b0;
            state_q    <= FILL;
            fill       <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            data_out   <= 1'b0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            sidx      <= sidx_d;
            vote      <= vote_d;
            prev_last <= samples[OVERSAMPLE-1];
            skip_next <= skip_d;
            state_q   <= state_d;
            fill      <= fill_d;
            wr_ptr    <= wr_ptr + AW'(accept);
            rd_ptr    <= rd_ptr + AW'(pop);
            overflow  <= overflow | drop;
            if (state_q == STREAM) begin
                if (pop) begin
                    data_out   <= mem[rd_ptr];
                    data_valid <= 1'b1;
                end else begin
                    underflow  <= 1'b1;
                    data_valid <= 1'b0;
                end
            end else begin
                data_valid <= 1'b0;
            end
        end
    end

    // Bit storage; entries are only read behind the fill count, so no reset is needed.
    always_ff @(posedge clock_480) begin
        if (accept != 2'd0) mem[wr_ptr] <= push_b0;
        if (accept == 2'd2) mem[wr_ptr + AW'(1)] <= push_b1;
    end

endmodule

// File: tb/tb_dr_phase_tracker_elastic.sv
module tb_dr_phase_tracker_elastic;
    localparam int OS    = 10;
    localparam int LT    = 4;
    localparam int DEPTH = 16;
    localparam int START = 8;

    logic                   clock_480 = 1'b0;
    logic                   reset;
    logic [OS-1:0]          samples;
    logic                   data_out, data_valid;
    logic [$clog2(OS)-1:0]  phase;
    logic [$clog2(DEPTH):0] fill_level;
    logic                   overflow, underflow;

    dr_phase_tracker_elastic #(
        .OVERSAMPLE(OS), .LOCK_THRESH(LT), .FIFO_DEPTH(DEPTH), .FIFO_START(START)
    ) dut (
        .clock_480(clock_480), .reset(reset), .samples(samples),
        .data_out(data_out), .data_valid(data_valid), .phase(phase),
        .fill_level(fill_level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clock_480 = ~clock_480;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: line state, phase index, vote, pending skip, bit queue and output flags.
    int m_sidx, m_vote;
    bit m_prev, m_skip, m_stream, m_dout, m_dv, m_ovf, m_udf;
    bit mq[$];
    bit line;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sidx = OS / 2; m_vote = 0; m_prev = 0; m_skip = 0;
        m_stream = 0; m_dout = 0; m_dv = 0; m_ovf = 0; m_udf = 0;
        mq.delete();
        line = 0;
    endtask

    task automatic model_step(input logic [OS-1:0] s);
        int nedge = 0;
        int k = 0;
        int eph, d, old_sidx;
        int dir = 0;
        bit left;
        bit emit[$];
        for (int i = 0; i < OS; i++) begin
            if (i == 0) left = m_prev; else left = s[i-1];
            if (s[i] != left) begin nedge++; k = i; end
        end
        m_prev = s[OS-1];
        if (nedge == 1) begin
            eph = (m_sidx - OS / 2 + OS) % OS;
            d   = ((k - eph) % OS + OS) % OS;
            if (d >= OS / 2) d -= OS;
            if (d > 0) m_vote++;
            else if (d < 0) m_vote--;
            if (m_vote == LT) begin m_vote = 0; dir = 1; end
            else if (m_vote == -LT) begin m_vote = 0; dir = -1; end
        end
        old_sidx = m_sidx;
        if (m_skip) begin
            m_skip = (dir == 1 && old_sidx == OS - 1);
        end else if (dir == -1 && old_sidx == 0) begin
            emit.push_back(s[0]);
            emit.push_back(s[OS-1]);
        end else begin
            emit.push_back(s[old_sidx]);
            m_skip = (dir == 1 && old_sidx == OS - 1);
        end
        m_sidx = (old_sidx + dir + OS) % OS;
        if (m_stream) begin
            if (mq.size() == 0) begin m_udf = 1; m_dv = 0; m_stream = 0; end
            else begin m_dout = mq.pop_front(); m_dv = 1; end
        end else begin
            m_dv = 0;
        end
        foreach (emit[j]) begin
            if (mq.size() < DEPTH) mq.push_back(emit[j]);
            else m_ovf = 1;
        end
        if (!m_stream && mq.size() >= START) m_stream = 1;
    endtask

    task automatic check_outputs();
        check("phase",      32'(phase),      32'(m_sidx));
        check("fill_level", 32'(fill_level), 32'(mq.size()));
        check("data_valid", 32'(data_valid), 32'(m_dv));
        check("data_out",   32'(data_out),   32'(m_dout));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("underflow",  32'(underflow),  32'(m_udf));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".data_out"},   32'(data_out),   0);
        check({tag, ".data_valid"}, 32'(data_valid), 0);
        check({tag, ".overflow"},   32'(overflow),   0);
        check({tag, ".underflow"},  32'(underflow),  0);
        check({tag, ".fill_level"}, 32'(fill_level), 0);
        check({tag, ".phase"},      32'(phase),      5);
    endtask

    task automatic cycle(input logic [OS-1:0] s);
        samples = s;
        model_step(s);
        @(posedge clock_480);
        #1;
        check_outputs();
    endtask

    // Single line transition placed so the phase error seen by the tracker is 'off'.
    task automatic drive_edge(input int off);
        logic [OS-1:0] s;
        int eph, k;
        eph = (m_sidx + OS / 2) % OS;
        k   = ((eph + off) % OS + OS) % OS;
        for (int i = 0; i < OS; i++) s[i] = (i < k) ? line : ~line;
        line = ~line;
        cycle(s);
    endtask

    task automatic drive_flat();
        cycle({OS{line}});
    endtask

    task automatic drive_noise();
        logic [OS-1:0] s;
        s = OS'($urandom);
        line = s[OS-1];
        cycle(s);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget, r;

        reset = 1'b0;
        samples = '0;
        model_reset();
        repeat (3) @(posedge clock_480);
        #1;
        check_reset_values("reset");
        reset = 1'b1;

        // Aligned stream: lone edge at k=0 every cycle.
        for (int i = 1; i <= 20; i++) begin
            drive_edge(0);
            if (i == 8) begin
                check("t1.fill_at_start", 32'(fill_level), 8);
                check("t1.valid_before", 32'(data_valid), 0);
            end
            if (i == 9) begin
                check("t1.valid_rise", 32'(data_valid), 1);
                check("t1.first_bit", 32'(data_out), 1);
            end
            if (i == 10) check("t1.second_bit", 32'(data_out), 0);
        end

        // Late drift: a 3-vote run plus a quiet cycle does not move; a 4-vote run does.
        repeat (3) drive_edge(1);
        drive_flat();
        check("t2.short_run_phase", 32'(phase), 5);
        repeat (3) drive_edge(-1);
        repeat (3) drive_edge(1);
        check("t2.three_votes_phase", 32'(phase), 5);
        drive_edge(1);
        check("t2.four_votes_phase", 32'(phase), 6);

        // Wrap-up slip: 9 -> 0, then one cycle with no push.
        budget = 0;
        while (m_sidx != 9 && budget < 100) begin drive_edge(1); budget++; end
        check("t3.reach_phase9", 32'(phase), 9);
        repeat (3) drive_edge(1);
        drive_edge(1);
        check("t3.wrap_phase", 32'(phase), 0);
        check("t3.wrap_fill", 32'(fill_level), 8);
        drive_edge(0);
        check("t3.skip_fill", 32'(fill_level), 7);

        // Wrap-down slip: 0 -> 9 pushes two bits.
        repeat (3) drive_edge(-1);
        check("t4.pre_phase", 32'(phase), 0);
        check("t4.pre_fill", 32'(fill_level), 7);
        drive_edge(-1);
        check("t4.wrap_phase", 32'(phase), 9);
        check("t4.wrap_fill", 32'(fill_level), 8);

        // Overflow boundary: keep slipping backwards until bits are dropped.
        budget = 0;
        while (!m_ovf && budget < 1500) begin drive_edge(-1); budget++; end
        check("t5.overflow", 32'(overflow), 1);
        check("t5.fill_full", 32'(fill_level), 16);
        repeat (50) drive_edge(-1);
        check("t5.fill_saturated", 32'(fill_level), 16);

        // Underflow boundary: keep slipping forwards until the buffer runs dry.
        budget = 0;
        while (!m_udf && budget < 2000) begin drive_edge(1); budget++; end
        check("t5.underflow", 32'(underflow), 1);
        check("t5.valid_dropped", 32'(data_valid), 0);
        check("t5.refill_start", 32'(fill_level), 1);
        repeat (7) drive_edge(0);
        check("t5.refill_mark", 32'(fill_level), 8);
        check("t5.refill_valid_low", 32'(data_valid), 0);
        drive_edge(0);
        check("t5.refill_valid_high", 32'(data_valid), 1);

        // Randomized line: mixed phase errors, quiet cycles and multi-edge noise.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) drive_flat();
            else if (r == 1) drive_noise();
            else drive_edge(int'($urandom_range(0, 9)) - 5);
        end

        // Steer occupancy to 10 while streaming, then reset asynchronously mid-cycle.
        budget = 0;
        while (!(m_stream && mq.size() == 10) && budget < 3000) begin
            drive_edge((mq.size() < 10) ? -1 : 1);
            budget++;
        end
        check("t6.pre_reset_fill", 32'(fill_level), 10);
        #2;
        reset = 1'b0;
        samples = '0;
        model_reset();
        #1;
        check_reset_values("t6.async");
        repeat (2) @(posedge clock_480);
        #1;
        check_reset_values("t6.held");
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive_edge(0);
            if (i == 8) check("t6.restart_fill", 32'(fill_level), 8);
            if (i == 9) begin
                check("t6.restart_valid", 32'(data_valid), 1);
                check("t6.restart_bit", 32'(data_out), 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
